// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the LPC host side and a UART transmitter, with a small
// launch FSM that hands one byte at a time to the transmitter and tracks its busy handshake.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int BUSY_WAIT  = 4
) (
  input  logic                  LPC_CLK,
  input  logic                  LPC_RST,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  input  logic                  ovf_clr,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WW    = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [WW-1:0]       WAIT_LAST = WW'(BUSY_WAIT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_r, wr_ptr_r;
  logic [DEPTH_LOG2:0]   count_r, count_s;
  logic                  empty_r, full_r, overflow_r;
  logic [7:0]            tx_data_r;
  logic                  tx_valid_r;
  logic [WW-1:0]         wait_cnt_r, wait_cnt_s;
  state_t                state_r, state_s;
  logic                  pop_s, push_s, drop_s;

  // Launch FSM: next state, busy-wait counter and the pop decision
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_r && !tx_busy) begin
          pop_s      = 1'b1;
          state_s    = WAIT_BUSY;
          wait_cnt_s = {WW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_s = WAIT_DONE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_s = IDLE;
        end else begin
          wait_cnt_s = wait_cnt_r + WW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: begin
        state_s    = IDLE;
        wait_cnt_s = {WW{1'b0}};
      end
    endcase
  end

  // Write acceptance: a full FIFO still takes a byte when a launch frees a slot at the same edge
  always_comb begin
    push_s = wr_valid & (~full_r | pop_s);
    drop_s = wr_valid & full_r & ~pop_s;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_s = count_r - (DEPTH_LOG2 + 1)'(1);
      default: count_s = count_r;
    endcase
  end

  // Control state, pointers, flags and the registered transmitter interface
  always_ff @(posedge LPC_CLK or posedge LPC_RST) begin
    if (LPC_RST) begin
      state_r    <= IDLE;
      wait_cnt_r <= {WW{1'b0}};
      rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
      wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
      count_r    <= {(DEPTH_LOG2 + 1){1'b0}};
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      count_r    <= count_s;
      empty_r    <= (count_s == {(DEPTH_LOG2 + 1){1'b0}});
      full_r     <= (count_s == DEPTH_CNT);
      overflow_r <= drop_s | (overflow_r & ~ovf_clr);
      tx_valid_r <= pop_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + DEPTH_LOG2'(1);
        tx_data_r <= mem[rd_ptr_r];
      end
    end
  end

  // Storage array; contents are don't-care after reset
  always_ff @(posedge LPC_CLK) begin
    if (push_s) begin
      mem[wr_ptr_r] <= wr_data;
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign count    = count_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (depth 16, BUSY_WAIT 4).
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       ovf_clr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;
  logic [4:0] count;
  logic       empty, full, overflow;

  logic       busy_manual, busy_model_en, model_busy;
  int         bcnt;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] launched[$];
  int         launch_cyc[$];

  uart_tx_fifo #(.DEPTH_LOG2(4), .BUSY_WAIT(4)) dut (
    .LPC_CLK(clk), .LPC_RST(rst), .wr_data(wr_data), .wr_valid(wr_valid),
    .ovf_clr(ovf_clr), .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .count(count), .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign tx_busy = busy_model_en ? model_busy : busy_manual;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every launch seen on the transmitter side
  always @(negedge clk) begin
    if (tx_valid === 1'b1) begin
      launched.push_back(tx_data);
      launch_cyc.push_back(cyc);
    end
  end

  // UART model: busy for 10 cycles, rising one cycle after tx_valid
  always @(posedge clk) begin
    if (!busy_model_en || rst) begin
      model_busy <= 1'b0;
      bcnt       <= 0;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) model_busy <= 1'b0;
    end else if (tx_valid) begin
      model_busy <= 1'b1;
      bcnt       <= 10;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_launches(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (launched.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (launched.size() >= n) ok = 1'b1;
  endtask

  task automatic clear_log();
    launched.delete();
    launch_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    clear_log();
    wr_data = 8'h41; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count_after_write got=%0d exp=1", count); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL single_no_early_launch got=%b exp=0", tx_valid); end
    tick();
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL single_tx_valid got=%b exp=1", tx_valid); end
    total++; if (tx_data !== 8'h41) begin bad++; $display("FAIL single_tx_data got=%h exp=41", tx_data); end
    total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL single_drained got count=%0d empty=%b exp 0/1", count, empty); end
    tick();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL single_valid_one_cycle got=%b exp=0", tx_valid); end
    total++; if (tx_data !== 8'h41) begin bad++; $display("FAIL single_data_hold got=%h exp=41", tx_data); end
    repeat (8) tick();
    total++; if (launched.size() !== 1) begin bad++; $display("FAIL single_launch_count got=%0d exp=1", launched.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    busy_model_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_data = 8'(i); wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    wait_launches(5, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d launches exp=5", launched.size()); end
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        total++; if (launched[i] !== 8'(i + 1)) begin bad++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, launched[i], 8'(i + 1)); end
      end
      for (int i = 1; i < 5; i++) begin
        total++; if (launch_cyc[i] - launch_cyc[i-1] !== 13) begin bad++; $display("FAIL b2b_gap[%0d] got=%0d exp=13", i, launch_cyc[i] - launch_cyc[i-1]); end
      end
    end
    repeat (20) tick();
    busy_model_en = 1'b0;
    total++; if (launched.size() !== 5) begin bad++; $display("FAIL b2b_no_extra got=%0d exp=5", launched.size()); end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_log();
    busy_manual = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'h10 + 8'(i); wr_valid = 1'b1;
      tick();
      if (i == 15) begin
        total++; if (full !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL ovf_at_16 got full=%b ovf=%b exp 1/0", full, overflow); end
      end
    end
    wr_valid = 1'b0;
    total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    ovf_clr = 1'b1; wr_data = 8'hEE; wr_valid = 1'b1;
    tick();
    ovf_clr = 1'b0; wr_valid = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_clr_vs_drop got=%b exp=1", overflow); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count_after_drop got=%0d exp=16", count); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    busy_manual = 1'b0;
    wait_launches(16, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_drain_timeout got=%0d launches exp=16", launched.size()); end
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        total++; if (launched[i] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, launched[i], 8'h10 + 8'(i)); end
      end
    end
    repeat (20) tick();
    total++; if (launched.size() !== 16) begin bad++; $display("FAIL ovf_dropped_launched got=%0d launches exp=16", launched.size()); end
  endtask

  task automatic test_busy_timeout();
    bit ok;
    clear_log();
    busy_manual = 1'b0;
    wr_data = 8'hA1; wr_valid = 1'b1;
    tick();
    wr_data = 8'hA2;
    tick();
    wr_valid = 1'b0;
    wait_launches(2, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_no_relaunch got=%0d launches exp=2", launched.size()); end
    if (ok) begin
      total++; if (launched[0] !== 8'hA1 || launched[1] !== 8'hA2) begin bad++; $display("FAIL timeout_order got=%h,%h exp=a1,a2", launched[0], launched[1]); end
      total++; if (launch_cyc[1] - launch_cyc[0] !== 5) begin bad++; $display("FAIL timeout_gap got=%0d exp=5", launch_cyc[1] - launch_cyc[0]); end
    end
    repeat (10) tick();
  endtask

  task automatic test_full_pop();
    bit ok;
    busy_manual = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h20 + 8'(i); wr_valid = 1'b1;
      tick();
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fullpop_full got=%b exp=1", full); end
    clear_log();
    busy_manual = 1'b0; wr_data = 8'h5A; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    total++; if (count !== 5'd16) begin bad++; $display("FAIL fullpop_count got=%0d exp=16", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_overflow got=%b exp=0", overflow); end
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h20) begin bad++; $display("FAIL fullpop_launch got v=%b d=%h exp 1/20", tx_valid, tx_data); end
    wait_launches(17, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL fullpop_drain_timeout got=%0d launches exp=17", launched.size()); end
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        total++; if (launched[i] !== 8'h20 + 8'(i)) begin bad++; $display("FAIL fullpop_order[%0d] got=%h exp=%h", i, launched[i], 8'h20 + 8'(i)); end
      end
      total++; if (launched[16] !== 8'h5A) begin bad++; $display("FAIL fullpop_last got=%h exp=5a", launched[16]); end
    end
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    busy_manual = 1'b0;
    wr_data = 8'hB0; wr_valid = 1'b1;
    tick();
    wr_data = 8'hB1;
    tick();
    wr_data = 8'hB2; busy_manual = 1'b1;
    tick();
    wr_data = 8'hB3;
    tick();
    wr_valid = 1'b0;
    total++; if (count !== 5'd3) begin bad++; $display("FAIL rstmid_pre_count got=%0d exp=3", count); end
    clear_log();
    #2 rst = 1'b1;
    #1;
    total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL rstmid_async got count=%0d empty=%b exp 0/1", count, empty); end
    total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL rstmid_tx got v=%b d=%h exp 0/00", tx_valid, tx_data); end
    repeat (2) tick();
    rst = 1'b0; busy_manual = 1'b0;
    repeat (10) tick();
    total++; if (launched.size() !== 0) begin bad++; $display("FAIL rstmid_spurious_launch got=%0d exp=0", launched.size()); end
    wr_data = 8'hC7; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    wait_launches(1, 20, ok);
    total++; if (!ok || launched[0] !== 8'hC7) begin bad++; $display("FAIL rstmid_new_write got n=%0d exp C7 launched", launched.size()); end
    repeat (8) tick();
  endtask

  initial begin
    rst = 1'b1; wr_data = 8'h00; wr_valid = 1'b0; ovf_clr = 1'b0;
    busy_manual = 1'b0; busy_model_en = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_busy_timeout();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter BUSY_WAIT, default 4, max cycles to wait for tx_busy to rise after a launch.
REQ-003 SHALL have port LPC_CLK  input  1  sole clock; all state rising-edge.
REQ-004 SHALL have port LPC_RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_data  input  8  byte from LPC host-interface side.
REQ-006 SHALL have port wr_valid  input  1  one-cycle write strobe for wr_data.
REQ-007 SHALL have port ovf_clr  input  1  clears sticky overflow flag.
REQ-008 SHALL have port tx_data  output  8  byte presented to UART transmitter.
REQ-009 SHALL have port tx_valid  output  1  one-cycle launch strobe to UART transmitter.
REQ-010 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-011 SHALL have port count  output  DEPTH_LOG2+1  bytes currently stored.
REQ-012 SHALL have port empty  output  1  count==0.
REQ-013 SHALL have port full  output  1  count==2**DEPTH_LOG2.
REQ-014 SHALL have port overflow  output  1  sticky: a write was dropped.

Function
REQ-015 SHALL store bytes in a circular buffer; rd/wr pointers DEPTH_LOG2 bits, wrapping from 2**DEPTH_LOG2-1 to 0.
REQ-016 SHALL accept wr_data at the rising edge where wr_valid=1 and (not full, or a pop occurs at that same edge).
REQ-017 SHALL drop wr_data when wr_valid=1, full=1 and no pop at that edge; set overflow=1; count and contents unchanged.
REQ-018 SHALL clear overflow on ovf_clr=1; if ovf_clr and a dropped write coincide, overflow SHALL end at 1.
REQ-019 SHALL implement launch FSM states IDLE, WAIT_BUSY, WAIT_DONE.
REQ-020 In IDLE with empty=0 and tx_busy=0, the next edge SHALL: register head byte into tx_data, assert tx_valid, advance rd pointer (pop), enter WAIT_BUSY.
REQ-021 tx_valid SHALL be high exactly one cycle per launch; tx_data SHALL hold the launched byte until the next launch.
REQ-022 In WAIT_BUSY, tx_busy=1 SHALL move to WAIT_DONE; BUSY_WAIT cycles elapsed without tx_busy=1 SHALL return to IDLE.
REQ-023 In WAIT_DONE, tx_busy=0 SHALL return to IDLE.
REQ-024 Launch-to-launch minimum SHALL be 3 cycles (launch, busy seen, busy low seen, IDLE decision).
REQ-025 Simultaneous write and pop SHALL leave count unchanged; write alone +1; pop alone -1; count SHALL never exceed depth or underflow.
REQ-026 A write into an empty FIFO SHALL be launchable at the following edge at the earliest (1-cycle write-to-launch latency minimum, 2 cycles to tx_valid).
REQ-027 Bytes SHALL be launched strictly in write order; no byte duplicated or lost except per REQ-017.
REQ-028 empty, full, count SHALL be derived from registered state, glitch-free, valid the cycle after each edge.

Reset
REQ-029 LPC_RST=1 SHALL asynchronously force: pointers 0, count 0, empty 1, full 0, overflow 0, tx_valid 0, tx_data 8'h00, FSM IDLE.
REQ-030 Reset asserted mid-transmission SHALL discard all stored bytes and abort any wait state; no tx_valid during or in the first cycle after reset release.
REQ-031 Storage array contents need not be reset.

Verification
REQ-032 Reset, write 8'h41 with tx_busy=0 -> tx_valid one cycle 2 edges later, tx_data=8'h41, count back to 0.
REQ-033 Write 8'h01..8'h05 back-to-back, model UART busy 10 cycles per byte starting 1 cycle after tx_valid -> 5 launches in order 01..05, none during busy.
REQ-034 Hold tx_busy=1, write 17 bytes (depth 16) -> full=1, count=16, overflow=1, 17th byte never launched; pulse ovf_clr -> overflow=0.
REQ-035 tx_busy never rises after a launch -> FSM returns to IDLE after BUSY_WAIT=4 cycles, next byte launched.
REQ-036 FIFO full, write coinciding with launch pop -> write accepted, count stays 16, overflow stays 0.
REQ-037 Assert LPC_RST while in WAIT_DONE with 3 bytes queued -> immediately count=0, empty=1, tx_valid=0; no launch until a new write.
